// File: rtl/hist_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hist_pkg
// Purpose : Shared types and defaults for the histogram batch scheduler.
//           Controller state encoding, default sizing constants and helpers
//           that give the reset-time [lo,hi] bounds of each bin (equal-width
//           bins tiling the whole observation range).
// Revision: 1.0 - initial release
// ============================================================================
package hist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COUNT   = 2'd2,
    EMIT    = 2'd3
  } hist_state_e;

  localparam int DATA_W_DFLT   = 8;
  localparam int BATCH_DFLT    = 4;
  localparam int NUM_BINS_DFLT = 4;
  localparam int CNT_W_DFLT    = 8;

  // Lower bound of bin i when the range [0, 2**data_w) is split evenly.
  function automatic int bin_lo(input int i, input int data_w, input int num_bins);
    return i * ((1 << data_w) / num_bins);
  endfunction

  // Upper bound (inclusive) of bin i for the same even split.
  function automatic int bin_hi(input int i, input int data_w, input int num_bins);
    return bin_lo(i, data_w, num_bins) + ((1 << data_w) / num_bins) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hist_bin_match.sv
`default_nettype none
// ============================================================================
// Module  : hist_bin_match
// Purpose : Combinational match counter. Counts how many of the BATCH
//           observations fall inside the inclusive range [lo, hi]
//           (unsigned). An inverted range (lo > hi) matches nothing.
// Ports   : obs   - BATCH packed observations
//           lo    - inclusive lower bound
//           hi    - inclusive upper bound
//           count - number of observations in range (0..BATCH)
// Revision: 1.0 - initial release
// ============================================================================
module hist_bin_match
  import hist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int BATCH  = BATCH_DFLT
) (
  input  logic [BATCH-1:0][DATA_W-1:0] obs,
  input  logic [DATA_W-1:0]            lo,
  input  logic [DATA_W-1:0]            hi,
  output logic [$clog2(BATCH):0]       count
);

  localparam int c_cw = $clog2(BATCH) + 1;

  always_comb begin
    count = '0;
    for (int i = 0; i < BATCH; i++) begin
      if ((obs[i] >= lo) && (obs[i] <= hi)) begin
        count = count + c_cw'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hist_batch_sched.sv
`default_nettype none
// ============================================================================
// Module  : hist_batch_sched
// Purpose : Histogram batch sequencer. Collects BATCH observations, then
//           evaluates one bin per cycle through a single shared match unit,
//           accumulates saturating per-bin running totals, and streams the
//           per-bin results out over a valid/ready handshake.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           start, clear          - begin batch / zero totals (IDLE only)
//           cfg_we/idx/lo/hi      - bin bound write port (IDLE only)
//           obs_valid/data/ready  - observation input stream
//           res_valid/ready       - result output handshake
//           res_bin/count/total   - result payload for the current bin
//           busy, done            - not-IDLE flag, end-of-emit pulse
// Revision: 1.0 - initial release
// ============================================================================
module hist_batch_sched
  import hist_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int BATCH    = BATCH_DFLT,
  parameter int NUM_BINS = NUM_BINS_DFLT,
  parameter int CNT_W    = CNT_W_DFLT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_BINS)-1:0] cfg_idx,
  input  logic [DATA_W-1:0]           cfg_lo,
  input  logic [DATA_W-1:0]           cfg_hi,
  input  logic                        obs_valid,
  input  logic [DATA_W-1:0]           obs_data,
  output logic                        obs_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [$clog2(NUM_BINS)-1:0] res_bin,
  output logic [$clog2(BATCH):0]      res_count,
  output logic [CNT_W-1:0]            res_total,
  output logic                        busy,
  output logic                        done
);

  localparam int c_idx_w = $clog2(NUM_BINS);
  localparam int c_oix_w = $clog2(BATCH);
  localparam int c_cw    = $clog2(BATCH) + 1;
  localparam int c_sum_w = ((CNT_W > c_cw) ? CNT_W : c_cw) + 1;
  localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
  localparam logic [c_idx_w-1:0] c_last_bin = c_idx_w'(NUM_BINS - 1);
  localparam logic [c_oix_w-1:0] c_last_obs = c_oix_w'(BATCH - 1);

  // Registered state
  hist_state_e                         state_q, state_d;
  logic [c_oix_w-1:0]                  obs_cnt_q, obs_cnt_d;
  logic [c_idx_w-1:0]                  bin_ptr_q, bin_ptr_d;
  logic [BATCH-1:0][DATA_W-1:0]        obs_buf_q, obs_buf_d;
  logic [NUM_BINS-1:0][DATA_W-1:0]     lo_q, lo_d;
  logic [NUM_BINS-1:0][DATA_W-1:0]     hi_q, hi_d;
  logic [NUM_BINS-1:0][c_cw-1:0]       batch_cnt_q, batch_cnt_d;
  logic [NUM_BINS-1:0][CNT_W-1:0]      total_q, total_d;
  logic                                obs_ready_q, obs_ready_d;
  logic                                res_valid_q, res_valid_d;
  logic [c_idx_w-1:0]                  res_bin_q, res_bin_d;
  logic [c_cw-1:0]                     res_count_q, res_count_d;
  logic [CNT_W-1:0]                    res_total_q, res_total_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;

  // Reset-time bounds and match datapath
  logic [NUM_BINS-1:0][DATA_W-1:0]     w_dflt_lo;
  logic [NUM_BINS-1:0][DATA_W-1:0]     w_dflt_hi;
  logic [c_cw-1:0]                     w_match_cnt;
  logic [c_sum_w-1:0]                  w_sum;
  logic [CNT_W-1:0]                    w_sat_total;

  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_dflt_bounds
    assign w_dflt_lo[gi] = DATA_W'(bin_lo(gi, DATA_W, NUM_BINS));
    assign w_dflt_hi[gi] = DATA_W'(bin_hi(gi, DATA_W, NUM_BINS));
  end

  // One shared match unit; the bounds of the bin under evaluation are muxed in.
  hist_bin_match #(
    .DATA_W (DATA_W),
    .BATCH  (BATCH)
  ) u_match (
    .obs   (obs_buf_q),
    .lo    (lo_q[bin_ptr_q]),
    .hi    (hi_q[bin_ptr_q]),
    .count (w_match_cnt)
  );

  // Widen before adding so the carry is visible for saturation.
  assign w_sum       = c_sum_w'(total_q[bin_ptr_q]) + c_sum_w'(w_match_cnt);
  assign w_sat_total = (w_sum > c_sum_w'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_W-1:0];

  always_comb begin
    state_d     = state_q;
    obs_cnt_d   = obs_cnt_q;
    bin_ptr_d   = bin_ptr_q;
    obs_buf_d   = obs_buf_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    batch_cnt_d = batch_cnt_q;
    total_d     = total_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // clear, cfg_we and start touch disjoint state, so all may act together.
        if (clear) begin
          total_d = '0;
        end
        if (cfg_we) begin
          lo_d[cfg_idx] = cfg_lo;
          hi_d[cfg_idx] = cfg_hi;
        end
        if (start) begin
          state_d   = COLLECT;
          obs_cnt_d = '0;
        end
      end
      COLLECT: begin
        if (obs_valid) begin
          obs_buf_d[obs_cnt_q] = obs_data;
          if (obs_cnt_q == c_last_obs) begin
            obs_cnt_d = '0;
            bin_ptr_d = '0;
            state_d   = COUNT;
          end else begin
            obs_cnt_d = obs_cnt_q + c_oix_w'(1);
          end
        end
      end
      COUNT: begin
        batch_cnt_d[bin_ptr_q] = w_match_cnt;
        total_d[bin_ptr_q]     = w_sat_total;
        if (bin_ptr_q == c_last_bin) begin
          bin_ptr_d = '0;
          state_d   = EMIT;
        end else begin
          bin_ptr_d = bin_ptr_q + c_idx_w'(1);
        end
      end
      EMIT: begin
        if (res_ready) begin
          if (bin_ptr_q == c_last_bin) begin
            bin_ptr_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bin_ptr_d = bin_ptr_q + c_idx_w'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with state_q.
    obs_ready_d = (state_d == COLLECT);
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == EMIT);
    res_bin_d   = res_bin_q;
    res_count_d = res_count_q;
    res_total_d = res_total_q;
    if (state_d == EMIT) begin
      res_bin_d   = bin_ptr_d;
      res_count_d = batch_cnt_d[bin_ptr_d];
      res_total_d = total_d[bin_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      obs_cnt_q   <= '0;
      bin_ptr_q   <= '0;
      obs_buf_q   <= '0;
      lo_q        <= w_dflt_lo;
      hi_q        <= w_dflt_hi;
      batch_cnt_q <= '0;
      total_q     <= '0;
      obs_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_bin_q   <= '0;
      res_count_q <= '0;
      res_total_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      obs_cnt_q   <= obs_cnt_d;
      bin_ptr_q   <= bin_ptr_d;
      obs_buf_q   <= obs_buf_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      batch_cnt_q <= batch_cnt_d;
      total_q     <= total_d;
      obs_ready_q <= obs_ready_d;
      res_valid_q <= res_valid_d;
      res_bin_q   <= res_bin_d;
      res_count_q <= res_count_d;
      res_total_q <= res_total_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign obs_ready = obs_ready_q;
  assign res_valid = res_valid_q;
  assign res_bin   = res_bin_q;
  assign res_count = res_count_q;
  assign res_total = res_total_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hist_batch_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_hist_batch_sched
// Purpose : Directed self-checking bench for hist_batch_sched, built with a
//           3-bit running total so saturation is reachable in two batches.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hist_batch_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_lo;
  logic [7:0] cfg_hi;
  logic       obs_valid;
  logic [7:0] obs_data;
  logic       obs_ready;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_bin;
  logic [2:0] res_count;
  logic [2:0] res_total;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hist_batch_sched #(
    .DATA_W   (8),
    .BATCH    (4),
    .NUM_BINS (4),
    .CNT_W    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .obs_valid (obs_valid),
    .obs_data  (obs_data),
    .obs_ready (obs_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bin   (res_bin),
    .res_count (res_count),
    .res_total (res_total),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_bin(input logic [1:0] idx, input logic [7:0] lo, input logic [7:0] hi);
    cfg_we = 1'b1; cfg_idx = idx; cfg_lo = lo; cfg_hi = hi;
    tick();
    cfg_we = 1'b0;
  endtask

  // Start a batch and feed four observations, one per cycle.
  task automatic feed(input logic [7:0] o0, input logic [7:0] o1,
                      input logic [7:0] o2, input logic [7:0] o3);
    logic [7:0] obs [4];
    obs[0] = o0; obs[1] = o1; obs[2] = o2; obs[3] = o3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_eq("obs_ready", obs_ready, 1);
      obs_valid = 1'b1;
      obs_data  = obs[i];
      tick();
    end
    obs_valid = 1'b0;
  endtask

  // Full batch: feed, check COUNT latency, optionally stall on bin 0, drain.
  task automatic run_batch(input logic [7:0] o0, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [7:0] o3,
                           input int c0, input int c1, input int c2, input int c3,
                           input int t0, input int t1, input int t2, input int t3,
                           input bit stall);
    int ec [4];
    int et [4];
    int lat;
    ec[0] = c0; ec[1] = c1; ec[2] = c2; ec[3] = c3;
    et[0] = t0; et[1] = t1; et[2] = t2; et[3] = t3;
    feed(o0, o1, o2, o3);
    // Now in the cycle after the last obs handshake; valid is due 4 edges later.
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk_eq("latency", lat, 4);
    if (stall) begin
      res_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
        start  = (s == 0);
        cfg_we = (s == 1);
        cfg_idx = 2'd0; cfg_lo = 8'd255; cfg_hi = 8'd255;
        tick();
        chk_eq("stall_valid", res_valid, 1);
        chk_eq("stall_bin", res_bin, 0);
        chk_eq("stall_count", res_count, ec[0]);
        chk_eq("stall_total", res_total, et[0]);
        chk_eq("stall_busy", busy, 1);
      end
      start  = 1'b0;
      cfg_we = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      chk_eq("res_valid", res_valid, 1);
      chk_eq("res_bin", res_bin, b);
      chk_eq("res_count", res_count, ec[b]);
      chk_eq("res_total", res_total, et[b]);
      chk_eq("done_early", done, 0);
      res_ready = 1'b1;
      tick();
    end
    res_ready = 1'b0;
    chk_eq("done_pulse", done, 1);
    chk_eq("valid_after", res_valid, 0);
    chk_eq("busy_after", busy, 0);
    tick();
    chk_eq("done_drop", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_lo = '0; cfg_hi = '0;
    obs_valid = 1'b0; obs_data = '0; res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk_eq("rst_obs_ready", obs_ready, 0);
    chk_eq("rst_res_valid", res_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_res_bin", res_bin, 0);
    chk_eq("rst_res_count", res_count, 0);
    chk_eq("rst_res_total", res_total, 0);

    // Default bounds: one observation per bin.
    run_batch(8'd10, 8'd70, 8'd130, 8'd200, 1, 1, 1, 1, 1, 1, 1, 1, 1'b0);

    // Bin 0 widened to the full range.
    cfg_bin(2'd0, 8'd0, 8'd255);
    run_batch(8'd5, 8'd5, 8'd5, 8'd5, 4, 0, 0, 0, 5, 1, 1, 1, 1'b0);

    // Inverted bin 2 matches nothing; bin 0 total 5+4 saturates at 7.
    cfg_bin(2'd2, 8'd200, 8'd100);
    run_batch(8'd150, 8'd150, 8'd150, 8'd150, 4, 0, 0, 0, 7, 1, 1, 1, 1'b0);

    // Reset after two observations discards the batch and restores defaults.
    start = 1'b1;
    tick();
    start = 1'b0;
    obs_valid = 1'b1; obs_data = 8'd1;
    tick();
    tick();
    obs_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("midrst_obs_ready", obs_ready, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_res_valid", res_valid, 0);

    // Fresh batch from slot 0, then a second one saturating bin 0.
    run_batch(8'd1, 8'd1, 8'd1, 8'd1, 4, 0, 0, 0, 4, 0, 0, 0, 1'b0);
    run_batch(8'd1, 8'd1, 8'd1, 8'd1, 4, 0, 0, 0, 7, 0, 0, 0, 1'b0);

    // Clear zeroes totals.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run_batch(8'd200, 8'd200, 8'd200, 8'd200, 0, 0, 0, 4, 0, 0, 0, 4, 1'b0);

    // Stall on bin 0 while pulsing start and cfg_we; neither may act.
    run_batch(8'd10, 8'd70, 8'd70, 8'd255, 1, 2, 0, 1, 1, 2, 0, 5, 1'b1);

    // Bin 0 must still be 0-63 after the ignored cfg write.
    run_batch(8'd10, 8'd10, 8'd10, 8'd10, 4, 0, 0, 0, 5, 2, 0, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hist_batch_sched.md
Name: hist_batch_sched

Overview:
- Sequencing controller for histogram bin counting.
- Collects a batch of 8-bit observations over a valid/ready stream and holds per-bin [lo,hi] bounds in registers.
- Evaluates one bin per cycle through a shared combinational match-count unit, keeps saturating running totals per bin, then emits per-bin results over a valid/ready handshake.
- Sits between the sample source and the histogram readout / host.

Parameters:
- DATA_W, 8: observation and bound width.
- BATCH, 4: observations per batch.
- NUM_BINS, 4: number of bins; power of 2, at most 2**DATA_W.
- CNT_W, 8: running-total width, saturating.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a batch; honoured only in IDLE.
- clear  in  1  zero all running totals; honoured only in IDLE.
- cfg_we  in  1  bound write strobe; ignored unless IDLE.
- cfg_idx  in  log2(NUM_BINS)  bin being configured.
- cfg_lo  in  DATA_W  inclusive lower bound.
- cfg_hi  in  DATA_W  inclusive upper bound.
- obs_valid  in  1  observation valid.
- obs_data  in  DATA_W  observation value.
- obs_ready  out  1  high only in COLLECT.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_bin  out  log2(NUM_BINS)  bin index of current result.
- res_count  out  log2(BATCH)+1  batch count for res_bin.
- res_total  out  CNT_W  running total for res_bin.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; obs_ready, res_valid, busy and done 0; res_bin, res_count and res_total 0; all totals 0; observation buffer 0. Bounds reset to bin i: lo = i*(2**DATA_W/NUM_BINS), hi = lo + 2**DATA_W/NUM_BINS - 1. With default parameters this gives 0-63, 64-127, 128-191, 192-255.
- Priority within IDLE: clear, then cfg_we, then start. All three may act in the same cycle.
- Bin match rule: observation o is in bin b iff lo_b <= o <= hi_b, unsigned compare. If lo > hi the bin matches nothing. Overlapping bins are allowed; one observation may count in several bins.

State machine:
- IDLE -> COLLECT on start.
- COLLECT: obs_ready=1. Each obs_valid & obs_ready handshake stores obs_data into buffer slot obs_cnt, then increments obs_cnt. The handshake with obs_cnt = BATCH-1 moves to COUNT; obs_cnt returns to 0.
- COUNT: lasts exactly NUM_BINS cycles, bin_ptr = 0..NUM_BINS-1.
  - Each cycle: batch_cnt[bin_ptr] <= match count; total[bin_ptr] <= min(total + count, 2**CNT_W - 1).
  - After bin NUM_BINS-1, go to EMIT with bin_ptr = 0.
- EMIT: res_valid=1; res_bin, res_count and res_total reflect bin_ptr.
  - On a res_valid & res_ready handshake, bin_ptr increments.
  - The handshake on bin NUM_BINS-1 deasserts res_valid, pulses done for one cycle, and returns to IDLE.
  - While res_ready=0, all res_* outputs are held stable.
- Latency: if the last obs handshake occurs in cycle k, COUNT runs in cycles k+1..k+NUM_BINS and res_valid rises in cycle k+NUM_BINS+1.
- Ignored inputs: start when not IDLE; obs_valid outside COLLECT; cfg_we, clear and start in any non-IDLE state.
- Reset mid-operation: rst in any state forces the full reset values in the next cycle. A partial batch is discarded, and totals and bounds are reinitialised.

Decomposition:
- Package hist_pkg: state enum (IDLE, COLLECT, COUNT, EMIT), default DATA_W/BATCH/NUM_BINS/CNT_W constants, and a function giving the default lo/hi for bin i.
- Sub-module hist_bin_match: combinational. Inputs are BATCH observations plus lo and hi; output is a log2(BATCH)+1 count of observations in range. It is instantiated once, and the controller muxes the bounds for bin_ptr into it.

Test Plan:
- Default bounds, obs 10, 70, 130, 200 -> results for bins 0..3 are each count=1, total=1. res_valid rises 5 cycles after the 4th obs handshake; done pulses once.
- cfg bin0 lo=0 hi=255, then obs 5, 5, 5, 5 -> bin0 count=4, bins 1-3 count=0.
- cfg bin2 lo=200 hi=100, obs 150, 150, 150, 150 -> bin2 count=0; bin1 (64-127) count=0; total for bin2 unchanged.
- CNT_W=3, two batches of obs 1, 1, 1, 1 -> bin0 total 4 after the first batch, 7 (saturated) after the second. A following clear in IDLE -> total 0.
- Hold res_ready=0 for 3 cycles in EMIT -> res_bin, res_count and res_total stable. start and cfg_we pulsed during EMIT have no effect.
- rst after 2 obs in COLLECT -> next cycle IDLE, obs_ready=0, busy=0. A new batch of 4 starts fresh with slot 0.
